// File: rtl/para_to_seq_load.sv
// para_to_seq_load: captures an RSA modulus (and, in CRT mode, a half-length
// precomputed operand) and streams both LSB-word-first onto a BUS_W-wide
// valid/ready bus, tagging each word with its job-wide index and a last flag.
module para_to_seq_load #(
    parameter int unsigned RSA_LEN = 512,
    parameter int unsigned BUS_W   = 32,
    parameter int unsigned PRE_LEN = 256,
    localparam int unsigned MOD_WORDS = RSA_LEN / BUS_W,
    localparam int unsigned PRE_WORDS = PRE_LEN / BUS_W,
    localparam int unsigned IDX_W_RAW = $clog2(MOD_WORDS + PRE_WORDS),
    localparam int unsigned IDX_W     = (IDX_W_RAW < 1) ? 1 : IDX_W_RAW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               crt,
    input  logic [RSA_LEN-1:0] mod_in,
    input  logic [PRE_LEN-1:0] predat_in,
    output logic [BUS_W-1:0]   data_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [IDX_W-1:0]   out_idx,
    output logic               busy,
    output logic               done
);

    localparam int unsigned LAST_MOD = MOD_WORDS - 1;
    localparam int unsigned LAST_CRT = MOD_WORDS + PRE_WORDS - 1;

    typedef enum logic [1:0] {
        IDLE,
        MOD,
        PRE
    } state_t;

    state_t             state;
    logic [RSA_LEN-1:0] shift_reg;
    logic [PRE_LEN-1:0] pre_q;
    logic               crt_q;
    logic [IDX_W-1:0]   idx_nxt;
    logic [IDX_W-1:0]   last_idx;

    // The low word of the shift register is always the word on the bus
    assign data_out = shift_reg[BUS_W-1:0];

    // Next index and final index of the latched job
    always_comb begin
        idx_nxt  = out_idx + IDX_W'(1);
        last_idx = crt_q ? IDX_W'(LAST_CRT) : IDX_W'(LAST_MOD);
    end

    // Sequencer: start capture, word shifting, MOD->PRE handover and completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            pre_q     <= '0;
            crt_q     <= 1'b0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rdy) begin
                        shift_reg <= mod_in;
                        pre_q     <= predat_in;
                        crt_q     <= crt;
                        out_idx   <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        out_last  <= !crt && (MOD_WORDS == 1);
                        state     <= MOD;
                    end
                end
                MOD, PRE: begin
                    if (out_ready) begin
                        // out_last already marks the final word, so completion
                        // needs no separate index compare against the mode
                        if (out_last) begin
                            state     <= IDLE;
                            shift_reg <= '0;
                            out_idx   <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            if (state == MOD && out_idx == IDX_W'(LAST_MOD)) begin
                                shift_reg <= RSA_LEN'(pre_q);
                                state     <= PRE;
                            end else begin
                                shift_reg <= shift_reg >> BUS_W;
                            end
                            out_idx  <= idx_nxt;
                            out_last <= (idx_nxt == last_idx);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_para_to_seq_load.sv
// Testbench for para_to_seq_load: scoreboard of expected words per instance,
// default 512/32/256 instance plus a 1024/64/512 instance.
module tb_para_to_seq_load;

    typedef struct {
        logic [63:0] data;
        int unsigned idx;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic         a_rdy = 1'b0, a_crt = 1'b0;
    logic [511:0] a_mod = '0;
    logic [255:0] a_pre = '0;
    logic [31:0]  a_data;
    logic         a_valid, a_ready = 1'b1, a_last, a_busy, a_done;
    logic [4:0]   a_idx;

    // Instance B: wide parameters
    logic          b_rdy = 1'b0, b_crt = 1'b0;
    logic [1023:0] b_mod = '0;
    logic [511:0]  b_pre = '0;
    logic [63:0]   b_data;
    logic          b_valid, b_ready = 1'b1, b_last, b_busy, b_done;
    logic [4:0]    b_idx;

    para_to_seq_load dut_a (
        .clk(clk), .rst(rst), .rdy(a_rdy), .crt(a_crt), .mod_in(a_mod),
        .predat_in(a_pre), .data_out(a_data), .out_valid(a_valid),
        .out_ready(a_ready), .out_last(a_last), .out_idx(a_idx),
        .busy(a_busy), .done(a_done)
    );

    para_to_seq_load #(.RSA_LEN(1024), .BUS_W(64), .PRE_LEN(512)) dut_b (
        .clk(clk), .rst(rst), .rdy(b_rdy), .crt(b_crt), .mod_in(b_mod),
        .predat_in(b_pre), .data_out(b_data), .out_valid(b_valid),
        .out_ready(b_ready), .out_last(b_last), .out_idx(b_idx),
        .busy(b_busy), .done(b_done)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    exp_t qa[$];
    exp_t qb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected words for instance A: 16 modulus words, then 8 pre words in CRT mode
    task automatic push_a(input logic crt, input logic [511:0] m, input logic [255:0] p);
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            e.data = {32'h0, m[k*32 +: 32]};
            e.idx  = k;
            e.last = !crt && (k == 15);
            qa.push_back(e);
        end
        if (crt) begin
            for (int k = 0; k < 8; k++) begin
                e.data = {32'h0, p[k*32 +: 32]};
                e.idx  = 16 + k;
                e.last = (k == 7);
                qa.push_back(e);
            end
        end
    endtask

    // Out_ready pattern 1,0,0,1 when stalling is enabled
    logic       rmode = 1'b0;
    logic [3:0] rpat  = 4'b1001;
    int unsigned rcnt = 0;
    always @(posedge clk) begin
        #1;
        if (rmode) begin
            a_ready = rpat[rcnt];
            rcnt    = (rcnt + 1) % 4;
        end else begin
            a_ready = 1'b1;
        end
    end

    // Monitor A: scoreboard compare, done timing, stall stability
    logic        a_pend = 1'b0, a_stall = 1'b0;
    logic [31:0] a_pdata;
    logic [4:0]  a_pidx;
    logic        a_plast;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            a_pend  = 1'b0;
            a_stall = 1'b0;
        end else begin
            check("a_done", a_done, a_pend);
            if (a_pend) check("a_busy_at_done", a_busy, 0);
            if (a_stall) begin
                check("a_hold_data", a_data, a_pdata);
                check("a_hold_idx", a_idx, a_pidx);
                check("a_hold_last", a_last, a_plast);
            end
            a_pend = 1'b0;
            if (a_valid && a_ready) begin
                if (qa.size() == 0) begin
                    check("a_unexpected_word", 1, 0);
                end else begin
                    e = qa.pop_front();
                    check("a_data", a_data, e.data);
                    check("a_idx", a_idx, 64'(e.idx));
                    check("a_last", a_last, e.last);
                    a_pend = e.last;
                end
            end
            a_stall = a_valid && !a_ready;
            a_pdata = a_data;
            a_pidx  = a_idx;
            a_plast = a_last;
        end
    end

    // Monitor B: scoreboard compare and done timing
    logic b_pend = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            b_pend = 1'b0;
        end else begin
            check("b_done", b_done, b_pend);
            b_pend = 1'b0;
            if (b_valid && b_ready) begin
                if (qb.size() == 0) begin
                    check("b_unexpected_word", 1, 0);
                end else begin
                    e = qb.pop_front();
                    check("b_data", b_data, e.data);
                    check("b_idx", b_idx, 64'(e.idx));
                    check("b_last", b_last, e.last);
                    b_pend = e.last;
                end
            end
        end
    end

    logic [511:0] mod_pa, mod_pc;
    logic [255:0] pre_pb;

    task automatic start_a(input logic crt, input logic [511:0] m, input logic [255:0] p);
        @(posedge clk); #1;
        a_crt = crt; a_mod = m; a_pre = p;
        push_a(crt, m, p);
        a_rdy = 1'b1;
        @(negedge clk);
        check("a_valid_before_start", a_valid, 0);
        @(posedge clk); #1;
        a_rdy = 1'b0; a_crt = ~crt; a_mod = ~m; a_pre = ~p;
        @(negedge clk);
        check("a_valid_first", a_valid, 1);
        check("a_busy_first", a_busy, 1);
        check("a_idx_first", a_idx, 0);
    endtask

    task automatic wait_done_a(input int unsigned budget);
        logic seen = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            if (a_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("a_done_seen", seen, 1);
        check("a_queue_drained", qa.size(), 0);
    endtask

    initial begin
        exp_t e;
        logic seen;
        for (int k = 0; k < 16; k++) mod_pa[k*32 +: 32] = 32'hA000_0000 + k;
        for (int k = 0; k < 16; k++) mod_pc[k*32 +: 32] = 32'hC000_0000 + k;
        for (int k = 0; k < 8; k++)  pre_pb[k*32 +: 32] = 32'hB000_0000 + k;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_a_valid", a_valid, 0);
        check("rst_a_data", a_data, 0);
        check("rst_a_idx", a_idx, 0);
        check("rst_a_last", a_last, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_done", a_done, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_b_data", b_data, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: modulus only
        start_a(1'b0, mod_pa, pre_pb);
        wait_done_a(100);

        // 2: CRT mode
        start_a(1'b1, mod_pa, pre_pb);
        wait_done_a(100);

        // 3: CRT mode with backpressure
        rmode = 1'b1;
        start_a(1'b1, mod_pa, pre_pb);
        wait_done_a(200);
        rmode = 1'b0;
        repeat (2) @(negedge clk);

        // 4: start ignored while busy, then back-to-back start in the done cycle
        start_a(1'b0, mod_pa, pre_pb);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (a_valid && a_idx == 5'd5) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("s4_reach_idx5", seen, 1);
        a_rdy = 1'b1; a_crt = 1'b1; a_mod = mod_pc;
        @(posedge clk); #1;
        a_rdy = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("s4_done_seen", seen, 1);
        check("s4_queue_drained", qa.size(), 0);
        a_crt = 1'b0; a_mod = mod_pc; a_rdy = 1'b1;
        push_a(1'b0, mod_pc, pre_pb);
        @(posedge clk); #1;
        a_rdy = 1'b0;
        @(negedge clk);
        check("s4_b2b_valid", a_valid, 1);
        check("s4_b2b_idx", a_idx, 0);
        wait_done_a(100);

        // 5: asynchronous reset mid-job
        start_a(1'b0, mod_pa, pre_pb);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (a_valid && a_idx == 5'd10) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("s5_reach_idx10", seen, 1);
        #2 rst = 1'b0;
        #1;
        check("s5_async_valid", a_valid, 0);
        check("s5_async_data", a_data, 0);
        check("s5_async_idx", a_idx, 0);
        check("s5_async_busy", a_busy, 0);
        check("s5_async_done", a_done, 0);
        qa.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        start_a(1'b1, mod_pa, pre_pb);
        wait_done_a(100);

        // 6: wide instance, CRT mode
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) b_mod[k*64 +: 64] = {32'hA000_0000 + k, 32'h5A5A_0000 + k};
        for (int k = 0; k < 8; k++)  b_pre[k*64 +: 64] = {32'hB000_0000 + k, 32'h3C3C_0000 + k};
        for (int k = 0; k < 16; k++) begin
            e.data = b_mod[k*64 +: 64]; e.idx = k; e.last = 1'b0;
            qb.push_back(e);
        end
        for (int k = 0; k < 8; k++) begin
            e.data = b_pre[k*64 +: 64]; e.idx = 16 + k; e.last = (k == 7);
            qb.push_back(e);
        end
        b_crt = 1'b1; b_rdy = 1'b1;
        @(posedge clk); #1;
        b_rdy = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (b_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("b_done_seen", seen, 1);
        check("b_queue_drained", qb.size(), 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/para_to_seq_load.md
Name: para_to_seq_load

Overview:
- Parametrised successor to the fixed 512/32 modulus serialiser.
- Captures an RSA modulus and, in CRT mode, a precomputed half-length operand.
- Streams both LSB-word-first onto a BUS_W-wide bus to the modular-multiplier operand RAM.
- Generalises operand, word and pre-segment widths, and adds valid/ready backpressure, last/index tagging, busy and done.

Parameters:
- RSA_LEN, 512: modulus width in bits. Must be a multiple of BUS_W.
- BUS_W, 32: output word width in bits.
- PRE_LEN, 256: precomputed-operand width in bits. Must be a multiple of BUS_W and no greater than RSA_LEN.
- Derived localparams:
  - MOD_WORDS = RSA_LEN/BUS_W
  - PRE_WORDS = PRE_LEN/BUS_W
  - IDX_W = clog2(MOD_WORDS+PRE_WORDS), minimum 1

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rdy  in  1  start request; sampled only in IDLE.
- crt  in  1  mode, sampled with rdy. 1 = modulus then pre-operand; 0 = modulus only.
- mod_in  in  RSA_LEN  modulus; captured on accepted start.
- predat_in  in  PRE_LEN  pre-operand; captured on accepted start.
- data_out  out  BUS_W  current word.
- out_valid  out  1  data_out, out_last and out_idx are valid.
- out_ready  in  1  consumer accepts the word. A transfer occurs when out_valid and out_ready are both 1.
- out_last  out  1  current word is the final word of the job.
- out_idx  out  IDX_W  index of the current word, counting from 0 across the whole job.
- busy  out  1  a job is in progress (state MOD or PRE).
- done  out  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - state = IDLE
  - shift register, data_out, out_idx all 0
  - out_valid, out_last, busy, done all 0
  - Reset mid-job aborts immediately. No further words are emitted, and no done is produced for the aborted job.
- States: IDLE, MOD, PRE.
- IDLE:
  - out_valid = 0.
  - If rdy = 1: load the shift register with mod_in, latch crt into crt_q, latch predat_in into pre_q, set out_idx = 0, go to MOD.
  - out_valid = 1 and busy = 1 from the next cycle. Start-to-first-word latency is exactly 1 cycle.
- MOD:
  - data_out = shift_reg[BUS_W-1:0].
  - On each transfer: shift right by BUS_W with zero fill, and increment out_idx.
  - On the transfer of word MOD_WORDS-1:
    - if crt_q = 1: load the shift register with pre_q zero-extended, go to PRE;
    - else: go to IDLE.
  - The next word is valid the cycle after a transfer. There are no bubbles between words while out_ready = 1.
- PRE:
  - Same shifting behaviour as MOD.
  - Indices run MOD_WORDS .. MOD_WORDS+PRE_WORDS-1.
  - Go to IDLE after the transfer of the last index.
- Backpressure: while out_valid = 1 and out_ready = 0, data_out, out_idx and out_last hold stable.
- out_last = 1 on:
  - index MOD_WORDS-1 when crt_q = 0;
  - index MOD_WORDS+PRE_WORDS-1 when crt_q = 1.
- done:
  - Asserted for exactly one cycle: the cycle after the final transfer, in which state = IDLE and busy = 0.
  - rdy is accepted in that same cycle, giving back-to-back jobs with one idle cycle between last word and next first word.
- rdy, crt, mod_in and predat_in changes while busy are ignored. Only the latched copies are used.
- PRE_LEN = 0 is not supported. The crt = 1 path requires PRE_WORDS ≥ 1.

Test Plan:
1. Defaults; crt = 0; mod_in word k = 32'hA000_0000+k; out_ready held 1.
   - Exactly 16 words A0000000..A000000F; out_idx 0..15; out_last only at idx 15.
   - First out_valid 1 cycle after rdy; done 1 cycle after idx 15.
2. crt = 1; mod_in as in scenario 1; predat_in word k = 32'hB000_0000+k.
   - 24 words: A0000000..A000000F, then B0000000..B0000007 at idx 16..23.
   - out_last only at idx 23.
3. crt = 1; out_ready toggles 1,0,0,1 repeating.
   - Identical word/index sequence to scenario 2; words stable during stalls; done only after idx 23 transfer.
4. rdy pulsed and mod_in changed at idx 5 of a running job, then rdy in the done cycle.
   - Running job is unaffected.
   - Second job starts from the done cycle and emits its first word 1 cycle later.
5. rst driven 0 asynchronously at idx 10.
   - Outputs go to 0 without waiting for clk; no done.
   - After release, a new rdy starts at idx 0.
6. RSA_LEN = 1024, BUS_W = 64, PRE_LEN = 512, crt = 1.
   - 16 + 8 = 24 words of 64 bits in correct order; out_idx width 5; out_last at idx 23.
